// File: rtl/multdiv_unit.sv
`timescale 1ns/1ps
// Iterative signed multiply/divide unit beside the single-cycle ALU.
// Operands become magnitudes on start; signs are re-applied in FIX.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  // state | meaning
  // IDLE  | waiting for a start strobe
  // RUN   | one shift-add / shift-subtract iteration per edge
  // FIX   | sign correction, result write, RDY raised
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_step, prod;
  logic [WIDTH-1:0]   opa_q, opb_q, mag_a, mag_b, diff, quot, quot_s, res_fix;
  logic [WIDTH:0]     sum, trial;
  logic               op_mul_q, sign_a_q, sign_b_q, neg, start, exc_fix;

  assign start = ctrl_MULT | ctrl_DIV;
  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign busy  = (state_q != IDLE) | data_resultRDY;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (cnt_q == LAST) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Multiply keeps {hi, multiplier}; divide keeps {remainder, quotient}.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    trial = acc_q[2*WIDTH-1:WIDTH-1];
    diff  = trial[WIDTH-1:0] - opb_q;
    if (op_mul_q)
      acc_step = {sum, acc_q[WIDTH-1:1]};
    else if (trial >= {1'b0, opb_q})
      acc_step = {diff, acc_q[WIDTH-2:0], 1'b1};
    else
      acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    neg     = sign_a_q ^ sign_b_q;
    prod    = neg ? -acc_q : acc_q;
    quot    = acc_q[WIDTH-1:0];
    quot_s  = neg ? -quot : quot;
    res_fix = quot_s;
    exc_fix = 1'b0;
    if (op_mul_q) begin
      res_fix = prod[WIDTH-1:0];
      exc_fix = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    end else if (opb_q == '0) begin
      res_fix = '0;
      exc_fix = 1'b1;
    end else begin
      // Only min_neg / -1 yields a positive quotient of 2^(WIDTH-1).
      exc_fix = quot[WIDTH-1] & ~neg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      op_mul_q       <= 1'b0;
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_resultRDY <= 1'b0;
      if (start) begin
        op_mul_q <= ctrl_MULT;
        sign_a_q <= data_operandA[WIDTH-1];
        sign_b_q <= data_operandB[WIDTH-1];
        opa_q    <= mag_a;
        opb_q    <= mag_b;
        acc_q    <= {{WIDTH{1'b0}}, (ctrl_MULT ? mag_b : mag_a)};
        cnt_q    <= '0;
      end else begin
        case (state_q)
          RUN: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
          end
          FIX: begin
            data_result    <= res_fix;
            data_exception <= exc_fix;
            data_resultRDY <= 1'b1;
            cnt_q          <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
`timescale 1ns/1ps
// Directed bench for multdiv_unit: latency, results, exceptions, abort and reset.
module tb_multdiv_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  int          checks = 0;
  int          errors = 0;

  multdiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!data_resultRDY && n < 100);
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc);
    int n;
    start(m, d, a, b);
    chk({tag, "_busy"}, 32'(busy), 1);
    wait_rdy(n);
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_res"}, data_result, exp_res);
    chk({tag, "_exc"}, 32'(data_exception), 32'(exp_exc));
    @(posedge clock); #1;
    chk({tag, "_rdy1cyc"}, 32'(data_resultRDY), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_hold"}, data_result, exp_res);
  endtask

  initial begin
    int n, seen;
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    #1;
    chk("rst_res", data_result, 0);
    chk("rst_rdy", 32'(data_resultRDY), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_exc", 32'(data_exception), 0);
    @(negedge clock); reset = 1'b0;

    run_op("mul_7x-6",   1, 0, 32'd7,        32'hFFFF_FFFA, 32'hFFFF_FFD6, 0);
    run_op("mul_ovf",    1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1);
    run_op("mul_minx1",  1, 0, 32'h8000_0000, 32'd1,        32'h8000_0000, 0);
    run_op("div_-7/2",   0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0);
    run_op("div_6/-3",   0, 1, 32'd6,        32'hFFFF_FFFD, 32'hFFFF_FFFE, 0);
    run_op("div_1/5",    0, 1, 32'd1,        32'd5,        32'h0000_0000, 0);
    run_op("div_by0",    0, 1, 32'd123,      32'd0,        32'h0000_0000, 1);
    run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Abort: a DIV started 10 edges into a MULT replaces it.
    start(1, 0, 32'd3, 32'd4);
    seen = 0;
    repeat (9) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen++;
    end
    start(0, 1, 32'd100, 32'd7);
    wait_rdy(n);
    chk("abort_lat", n, 33);
    chk("abort_res", data_result, 32'd14);
    chk("abort_no_early_rdy", seen, 0);
    @(posedge clock); #1;
    chk("abort_idle", 32'(busy), 0);

    // Reset 20 edges into an operation drops it.
    start(1, 0, 32'd9, 32'd9);
    repeat (20) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    chk("midrst_res", data_result, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rdy", 32'(data_resultRDY), 0);
    @(negedge clock); reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen++;
    end
    chk("midrst_no_rdy", seen, 0);
    chk("midrst_res_after", data_result, 0);

    run_op("both_5x5", 1, 1, 32'd5, 32'd5, 32'd25, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
